fnd_disp_sched: RTL and testbench

- Display scheduler and converter that drives the four BCD digit inputs (thous, hundreds, tens, ones) of the 4-digit FND scan array.
- Shares the display between two requesters:
  - the continuous game score (low priority);
  - a timed popup value such as combo or judgement count (high priority, held for a fixed time).
- Converts the selected 14-bit binary value to BCD with an iterative double-dabble sequencer.
- Applies leading-zero blanking and presents all four digits atomically.

---
 rtl/fnd_disp_sched.sv | 122 ++++++++++++
 tb/tb_fnd_disp_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fnd_disp_sched.sv
// fnd_disp_sched: arbitrates score/popup for the 4-digit FND, converts to BCD
// with a 14-step double dabble and presents blanked digits atomically.
`default_nettype none

module fnd_disp_sched #(
   parameter int unsigned HOLD_TICKS = 1000,
   parameter logic [3:0]  BLANK_CODE = 4'd15
) (
   input  logic        clk_1k,
   input  logic        rst,
   input  logic [13:0] score_bin,
   input  logic        popup_req,
   input  logic [13:0] popup_bin,
   output logic        popup_ack,
   output logic        busy,
   output logic        src,
   output logic [3:0]  thous,
   output logic [3:0]  hundreds,
   output logic [3:0]  tens,
   output logic [3:0]  ones
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      UPDATE = 2'd3
   } state_t;

   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_TICKS);
   localparam logic [3:0]  LAST_SHIFT = 4'd13;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  shift_cnt;
   logic [15:0] hold_cnt;
   logic [13:0] popup_latch;
   logic [13:0] bin_sr;
   logic [15:0] bcd_sr;
   logic [15:0] bcd_adj;
   logic        tag;
   logic [13:0] operand_raw;
   logic [13:0] operand;

   always_ff @(posedge clk_1k) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (shift_cnt == LAST_SHIFT) state_nxt = UPDATE;
         UPDATE:  state_nxt = LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == LOAD) || (state == SHIFT);

   // An active hold selects the popup latch; values beyond four digits saturate.
   assign operand_raw = (hold_cnt != 16'd0) ? popup_latch : score_bin;
   assign operand     = (operand_raw > 14'd9999) ? 14'd9999 : operand_raw;

   always_comb begin
      bcd_adj = bcd_sr;
      for (int i = 0; i < 4; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk_1k) begin
      if (!rst) begin
         popup_ack   <= 1'b0;
         hold_cnt    <= 16'd0;
         popup_latch <= 14'd0;
         bin_sr      <= 14'd0;
         bcd_sr      <= 16'd0;
         shift_cnt   <= 4'd0;
         tag         <= 1'b0;
         src         <= 1'b0;
         thous       <= BLANK_CODE;
         hundreds    <= BLANK_CODE;
         tens        <= BLANK_CODE;
         ones        <= 4'd0;
      end else begin
         popup_ack <= popup_req;
         if (popup_req) begin
            popup_latch <= popup_bin;
            hold_cnt    <= HOLD_LOAD;
         end else if (hold_cnt != 16'd0) begin
            hold_cnt <= hold_cnt - 16'd1;
         end

         case (state)
            LOAD: begin
               bin_sr    <= operand;
               bcd_sr    <= 16'd0;
               tag       <= (hold_cnt != 16'd0);
               shift_cnt <= 4'd0;
            end
            SHIFT: begin
               {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
               shift_cnt        <= shift_cnt + 4'd1;
            end
            UPDATE: begin
               src      <= tag;
               thous    <= (bcd_sr[15:12] == 4'd0) ? BLANK_CODE : bcd_sr[15:12];
               hundreds <= (bcd_sr[15:8]  == 8'd0) ? BLANK_CODE : bcd_sr[11:8];
               tens     <= (bcd_sr[15:4]  == 12'd0) ? BLANK_CODE : bcd_sr[7:4];
               ones     <= bcd_sr[3:0];
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fnd_disp_sched.sv
// Directed self-checking bench for fnd_disp_sched with a short popup hold.
`default_nettype none

module tb_fnd_disp_sched;

   logic        clk_1k = 1'b0;
   logic        rst;
   logic [13:0] score_bin;
   logic        popup_req;
   logic [13:0] popup_bin;
   logic        popup_ack;
   logic        busy;
   logic        src;
   logic [3:0]  thous, hundreds, tens, ones;
   logic [15:0] digits;

   int errors = 0;
   int checks = 0;
   int spur   = 0;

   always #5 clk_1k = ~clk_1k;

   fnd_disp_sched #(.HOLD_TICKS(100), .BLANK_CODE(4'd15)) dut (
      .clk_1k    (clk_1k),
      .rst       (rst),
      .score_bin (score_bin),
      .popup_req (popup_req),
      .popup_bin (popup_bin),
      .popup_ack (popup_ack),
      .busy      (busy),
      .src       (src),
      .thous     (thous),
      .hundreds  (hundreds),
      .tens      (tens),
      .ones      (ones)
   );

   assign digits = {thous, hundreds, tens, ones};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Digits may only move on the edge that leaves UPDATE, or under reset.
   logic [15:0] prev_digits = 16'hFFF0;
   logic        prev_busy   = 1'b0;
   always @(posedge clk_1k) begin
      #1;
      if ((digits !== prev_digits) && (rst === 1'b1) && (prev_busy === 1'b1)) spur++;
      prev_digits = digits;
      prev_busy   = busy;
   end

   // Returns at the negedge just after an UPDATE edge (next LOAD cycle).
   task automatic wait_upd();
      int n;
      n = 0;
      while (busy !== 1'b1 && n < 40) begin
         @(negedge clk_1k);
         n++;
      end
      while (busy !== 1'b0 && n < 80) begin
         @(negedge clk_1k);
         n++;
      end
      if (n >= 80) check("upd_timeout", 32'(n), 32'd0);
      @(negedge clk_1k);
   endtask

   task automatic show(input logic [13:0] val, input logic [15:0] exp, input string tag);
      score_bin = val;
      wait_upd();
      check(tag, 32'(digits), 32'(exp));
      check({tag, "_src"}, 32'(src), 32'd0);
   endtask

   task automatic pulse(input logic [13:0] val);
      popup_req = 1'b1;
      popup_bin = val;
      @(negedge clk_1k);
      popup_req = 1'b0;
      popup_bin = 14'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      rst = 1'b0; score_bin = 14'd0; popup_req = 1'b0; popup_bin = 14'd0;
      repeat (3) @(negedge clk_1k);
      check("rst_digits", 32'(digits), 32'h0000FFF0);
      check("rst_src",    32'(src),    32'd0);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_ack",    32'(popup_ack), 32'd0);
      rst = 1'b1;
      @(negedge clk_1k);
      check("post_rst_digits", 32'(digits), 32'h0000FFF0);

      wait_upd();
      check("zero_digits", 32'(digits), 32'h0000FFF0);
      check("zero_src",    32'(src),    32'd0);
      nb = 0;
      for (int i = 0; i < 16; i++) begin
         if (busy === 1'b1) nb++;
         @(negedge clk_1k);
      end
      check("busy_duty", 32'(nb), 32'd15);

      show(14'd1234,  16'h1234, "s1234");
      show(14'd905,   16'hF905, "s905");
      show(14'd70,    16'hFF70, "s70");
      show(14'd1000,  16'h1000, "s1000");
      show(14'd5,     16'hFFF5, "s5");
      show(14'd12000, 16'h9999, "sat12000");
      show(14'd9999,  16'h9999, "s9999");
      show(14'd1234,  16'h1234, "s1234b");

      // Popup issued in a LOAD cycle: that conversion still shows the score.
      popup_req = 1'b1;
      popup_bin = 14'd42;
      @(negedge clk_1k);
      popup_req = 1'b0;
      popup_bin = 14'd0;
      check("ack_pulse", 32'(popup_ack), 32'd1);
      @(negedge clk_1k);
      check("ack_drop",  32'(popup_ack), 32'd0);
      wait_upd();
      check("pop_old_op", 32'(digits), 32'h00001234);
      wait_upd();
      check("pop_digits", 32'(digits), 32'h0000FF42);
      check("pop_src",    32'(src),    32'd1);
      repeat (5) wait_upd();
      check("pop_late_src", 32'(src), 32'd1);
      wait_upd();
      check("expire_digits", 32'(digits), 32'h00001234);
      check("expire_src",    32'(src),    32'd0);

      // Retrigger 48 cycles into a hold.
      pulse(14'd42);
      wait_upd();
      wait_upd();
      check("re_first", 32'(digits), 32'h0000FF42);
      wait_upd();
      pulse(14'd7);
      wait_upd();
      check("re_inflight", 32'(digits), 32'h0000FF42);
      wait_upd();
      check("re_digits", 32'(digits), 32'h0000FFF7);
      check("re_src",    32'(src),    32'd1);
      repeat (5) wait_upd();
      check("re_held_digits", 32'(digits), 32'h0000FFF7);
      check("re_held_src",    32'(src),    32'd1);
      wait_upd();
      check("re_expire", 32'(digits), 32'h00001234);
      check("re_expire_src", 32'(src), 32'd0);

      // Reset in the middle of SHIFT with a popup on display.
      pulse(14'd42);
      wait_upd();
      wait_upd();
      check("mr_pop_src", 32'(src), 32'd1);
      repeat (4) @(negedge clk_1k);
      rst = 1'b0;
      @(negedge clk_1k);
      check("mr_digits", 32'(digits), 32'h0000FFF0);
      check("mr_src",    32'(src),    32'd0);
      check("mr_busy",   32'(busy),   32'd0);
      @(negedge clk_1k);
      rst = 1'b1;
      wait_upd();
      check("mr_after1", 32'(digits), 32'h00001234);
      check("mr_after1_src", 32'(src), 32'd0);
      wait_upd();
      check("mr_after2_src", 32'(src), 32'd0);

      check("atomic", 32'(spur), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
